// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the multicycle MIPS datapath
package mips_pkg;

  // Branch condition codes carried by cond_sel.
  localparam logic [2:0] COND_NE     = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_GT     = 3'd2;
  localparam logic [2:0] COND_LT     = 3'd3;
  localparam logic [2:0] COND_GE     = 3'd4;
  localparam logic [2:0] COND_LE     = 3'd5;
  localparam logic [2:0] COND_LTU    = 3'd6;
  localparam logic [2:0] COND_ALWAYS = 3'd7;

  // Number of distinct legal codes; anything at or above this is illegal.
  localparam int COND_LEGAL_N = 8;

  // Bit positions inside the 4-bit {Z,N,C,V} flag vector.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAG_W = 4;

  // Branch-condition FSM encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EVAL = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Clear wins over increment; increments stop once the counter is all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_write_cond_unit.sv
// rtl/pc_write_cond_unit.sv - branch condition resolver and PC write enable
module pc_write_cond_unit
  import mips_pkg::*;
#(
  parameter int COND_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              cond_valid,
  input  logic [COND_W-1:0] cond_sel,
  input  logic              pc_write,
  input  logic              clear_stats,
  output logic              cond_done,
  output logic              cond_taken,
  output logic              cond_illegal,
  output logic              pc_write_en,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  nottaken_count
);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [FLAG_W-1:0] flags;
  logic [COND_W-1:0] sel_q;

  // Zero-extended copy of the held code so the legality test works for any COND_W.
  logic [31:0]       sel_ext;
  logic [2:0]        code;
  logic              code_legal;
  logic              cond_hit;
  logic              f_z;
  logic              f_n;
  logic              f_c;
  logic              f_v;
  logic              inc_taken;
  logic              inc_nottaken;

  // Flag register: captures the ALU flags whenever the datapath asks for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (flag_we) begin
      flags[FLAG_Z] <= alu_zero;
      flags[FLAG_N] <= alu_neg;
      flags[FLAG_C] <= alu_carry;
      flags[FLAG_V] <= alu_ovf;
    end
  end

  // Next state: any request lands in EVAL, from either state, so back-to-back
  // requests resolve on consecutive cycles without a bubble.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = cond_valid ? ST_EVAL : ST_IDLE;
      ST_EVAL: state_next = cond_valid ? ST_EVAL : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; the asynchronous reset drops cond_done immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture: the code is held for the EVAL cycle that follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
    end else if (cond_valid) begin
      sel_q <= cond_sel;
    end
  end

  assign sel_ext    = 32'(sel_q);
  assign code       = sel_ext[2:0];
  assign code_legal = (sel_ext < 32'(COND_LEGAL_N));

  assign f_z = flags[FLAG_Z];
  assign f_n = flags[FLAG_N];
  assign f_c = flags[FLAG_C];
  assign f_v = flags[FLAG_V];

  // Condition decode from registered code and registered flags only.
  always_comb begin
    cond_hit = 1'b0;
    case (code)
      COND_NE:     cond_hit = ~f_z;
      COND_EQ:     cond_hit = f_z;
      COND_GT:     cond_hit = ~f_z & ~(f_n ^ f_v);
      COND_LT:     cond_hit = f_n ^ f_v;
      COND_GE:     cond_hit = ~(f_n ^ f_v);
      COND_LE:     cond_hit = f_z | (f_n ^ f_v);
      COND_LTU:    cond_hit = ~f_c;
      COND_ALWAYS: cond_hit = 1'b1;
      default:     cond_hit = 1'b0;
    endcase
  end

  assign cond_done    = (state == ST_EVAL);
  assign cond_taken   = cond_done & code_legal & cond_hit;
  assign cond_illegal = cond_done & ~code_legal;

  // Unconditional writes bypass the evaluation path entirely.
  assign pc_write_en  = pc_write | (cond_done & cond_taken);

  // Every resolved request bumps exactly one counter; illegal codes count as not taken.
  assign inc_taken    = cond_done & cond_taken;
  assign inc_nottaken = cond_done & ~cond_taken;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_stats),
    .inc   (inc_taken),
    .count (taken_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_nottaken_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_stats),
    .inc   (inc_nottaken),
    .count (nottaken_count)
  );

endmodule

// File: tb/tb_pc_write_cond_unit.sv
// tb/tb_pc_write_cond_unit.sv - self-checking bench for pc_write_cond_unit
module tb_pc_write_cond_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flag_we = 1'b0;
  logic       alu_zero = 1'b0;
  logic       alu_neg = 1'b0;
  logic       alu_carry = 1'b0;
  logic       alu_ovf = 1'b0;
  logic       cond_valid = 1'b0;
  logic [3:0] sel4 = 4'd0;
  logic       pc_write = 1'b0;
  logic       clear_stats = 1'b0;

  logic        a_done, a_taken, a_ill, a_pcwe;
  logic [15:0] a_tc, a_nc;
  logic        b_done, b_taken, b_ill, b_pcwe;
  logic [1:0]  b_tc, b_nc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_write_cond_unit #(.COND_W(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flag_we(flag_we),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .cond_valid(cond_valid), .cond_sel(sel4[2:0]), .pc_write(pc_write),
    .clear_stats(clear_stats), .cond_done(a_done), .cond_taken(a_taken),
    .cond_illegal(a_ill), .pc_write_en(a_pcwe), .taken_count(a_tc), .nottaken_count(a_nc)
  );

  pc_write_cond_unit #(.COND_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flag_we(flag_we),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .cond_valid(cond_valid), .cond_sel(sel4), .pc_write(pc_write),
    .clear_stats(clear_stats), .cond_done(b_done), .cond_taken(b_taken),
    .cond_illegal(b_ill), .pc_write_en(b_pcwe), .taken_count(b_tc), .nottaken_count(b_nc)
  );

  // Reference model: index 0 tracks dut_a (3-bit code, 16-bit counters), index 1 dut_b.
  bit m_eval [2];
  int m_sel  [2];
  int m_tc   [2];
  int m_nc   [2];
  int m_max  [2] = '{65535, 3};
  bit mz, mn, mc, mv;

  // Branch rules as arithmetic comparisons on the flags.
  function automatic bit cond_true(int code, bit z, bit n, bit c, bit v);
    if (code > 7) return 1'b0;
    case (code)
      0: return !z;
      1: return z;
      2: return !z && (n == v);
      3: return n != v;
      4: return n == v;
      5: return z || (n != v);
      6: return !c;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_eval[k] = 1'b0; m_sel[k] = 0; m_tc[k] = 0; m_nc[k] = 0;
    end
    mz = 0; mn = 0; mc = 0; mv = 0;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (m_eval[k]) begin
        if (m_sel[k] < 8 && cond_true(m_sel[k], mz, mn, mc, mv))
          m_tc[k] = (m_tc[k] + 1 > m_max[k]) ? m_max[k] : m_tc[k] + 1;
        else
          m_nc[k] = (m_nc[k] + 1 > m_max[k]) ? m_max[k] : m_nc[k] + 1;
      end
      if (clear_stats) begin
        m_tc[k] = 0; m_nc[k] = 0;
      end
      m_eval[k] = cond_valid;
      if (cond_valid) m_sel[k] = (k == 0) ? int'(sel4 % 8) : int'(sel4);
    end
    if (flag_we) begin
      mz = alu_zero; mn = alu_neg; mc = alu_carry; mv = alu_ovf;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    for (int k = 0; k < 2; k++) begin
      bit legal, e_taken;
      legal   = m_sel[k] < 8;
      e_taken = m_eval[k] && legal && cond_true(m_sel[k], mz, mn, mc, mv);
      if (k == 0) begin
        chk({tag, " a.done"},  32'(a_done),  32'(m_eval[k]));
        chk({tag, " a.taken"}, 32'(a_taken), 32'(e_taken));
        chk({tag, " a.ill"},   32'(a_ill),   32'(m_eval[k] && !legal));
        chk({tag, " a.pcwe"},  32'(a_pcwe),  32'(pc_write || e_taken));
        chk({tag, " a.tc"},    32'(a_tc),    32'(m_tc[k]));
        chk({tag, " a.nc"},    32'(a_nc),    32'(m_nc[k]));
      end else begin
        chk({tag, " b.done"},  32'(b_done),  32'(m_eval[k]));
        chk({tag, " b.taken"}, 32'(b_taken), 32'(e_taken));
        chk({tag, " b.ill"},   32'(b_ill),   32'(m_eval[k] && !legal));
        chk({tag, " b.pcwe"},  32'(b_pcwe),  32'(pc_write || e_taken));
        chk({tag, " b.tc"},    32'(b_tc),    32'(m_tc[k]));
        chk({tag, " b.nc"},    32'(b_nc),    32'(m_nc[k]));
      end
    end
  endtask

  task automatic drive(bit fwe, bit z, bit n, bit c, bit v, bit cv, logic [3:0] s, bit pw, bit clr);
    flag_we = fwe; alu_zero = z; alu_neg = n; alu_carry = c; alu_ovf = v;
    cond_valid = cv; sel4 = s; pc_write = pw; clear_stats = clr;
  endtask

  typedef struct {
    bit fwe, z, n, c, v, cv;
    logic [3:0] sel;
    bit pw, clr;
    bit e_done, e_taken, e_ill, e_pcwe;
    int e_tc, e_nc;
  } vec_t;

  function automatic vec_t mk(bit fwe, bit z, bit n, bit c, bit v, bit cv, int s, bit pw, bit clr,
                              bit ed, bit et, bit ei, bit ep, int tc, int nc);
    vec_t r;
    r.fwe = fwe; r.z = z; r.n = n; r.c = c; r.v = v; r.cv = cv; r.sel = 4'(s);
    r.pw = pw; r.clr = clr; r.e_done = ed; r.e_taken = et; r.e_ill = ei; r.e_pcwe = ep;
    r.e_tc = tc; r.e_nc = nc;
    return r;
  endfunction

  // Expectations for dut_b (4-bit code, 2-bit counters), seen mid-cycle of each row.
  vec_t tbl [21];

  initial begin
    tbl[0]  = mk(1,1,0,0,0, 0,0, 0,0,  0,0,0,0, 0,0);
    tbl[1]  = mk(0,0,0,0,0, 1,1, 0,0,  0,0,0,0, 0,0);
    tbl[2]  = mk(0,0,0,0,0, 0,0, 0,0,  1,1,0,1, 0,0);
    tbl[3]  = mk(1,0,1,0,0, 1,3, 0,0,  0,0,0,0, 1,0);
    tbl[4]  = mk(0,0,0,0,0, 0,0, 0,0,  1,1,0,1, 1,0);
    tbl[5]  = mk(1,0,1,0,0, 1,2, 0,0,  0,0,0,0, 2,0);
    tbl[6]  = mk(0,0,0,0,0, 0,0, 0,0,  1,0,0,0, 2,0);
    tbl[7]  = mk(1,1,0,0,0, 1,0, 0,0,  0,0,0,0, 2,1);
    tbl[8]  = mk(0,0,0,0,0, 1,1, 0,0,  1,0,0,0, 2,1);
    tbl[9]  = mk(0,0,0,0,0, 1,7, 0,0,  1,1,0,1, 2,2);
    tbl[10] = mk(1,0,0,0,0, 0,0, 0,0,  1,1,0,1, 3,2);
    tbl[11] = mk(1,1,0,0,0, 1,1, 0,0,  0,0,0,0, 3,2);
    tbl[12] = mk(1,0,0,0,0, 0,0, 0,0,  1,1,0,1, 3,2);
    tbl[13] = mk(0,0,0,0,0, 0,0, 0,0,  0,0,0,0, 3,2);
    tbl[14] = mk(0,0,0,0,0, 1,9, 1,0,  0,0,0,1, 3,2);
    tbl[15] = mk(0,0,0,0,0, 0,0, 0,0,  1,0,1,0, 3,2);
    tbl[16] = mk(0,0,0,0,0, 0,0, 0,0,  0,0,0,0, 3,3);
    tbl[17] = mk(0,0,0,0,0, 1,7, 0,0,  0,0,0,0, 3,3);
    tbl[18] = mk(0,0,0,0,0, 0,0, 0,1,  1,1,0,1, 3,3);
    tbl[19] = mk(0,0,0,0,0, 0,0, 0,0,  0,0,0,0, 0,0);
    tbl[20] = mk(0,0,0,0,0, 0,0, 1,0,  0,0,0,1, 0,0);

    // Reset state, with pc_write high to show it passes straight through.
    model_reset();
    drive(0,0,0,0,0, 0,4'd0, 1,0);
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset b.pcwe", 32'(b_pcwe), 32'd1);
    pc_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(tbl[i].fwe, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v,
            tbl[i].cv, tbl[i].sel, tbl[i].pw, tbl[i].clr);
      @(negedge clk);
      chk({tag, " done"},  32'(b_done),  32'(tbl[i].e_done));
      chk({tag, " taken"}, 32'(b_taken), 32'(tbl[i].e_taken));
      chk({tag, " ill"},   32'(b_ill),   32'(tbl[i].e_ill));
      chk({tag, " pcwe"},  32'(b_pcwe),  32'(tbl[i].e_pcwe));
      chk({tag, " tc"},    32'(b_tc),    32'(tbl[i].e_tc));
      chk({tag, " nc"},    32'(b_nc),    32'(tbl[i].e_nc));
      check_model(tag);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
      @(negedge clk);
      check_model("rand");
      @(posedge clk);
      model_edge();
      #1;
    end

    // Reset arriving in the middle of an EVAL cycle.
    drive(0,0,0,0,0, 1,4'd7, 0,0);
    @(negedge clk);
    check_model("pre-rst");
    @(posedge clk);
    model_edge();
    #1;
    drive(0,0,0,0,0, 0,4'd0, 0,0);
    #1;
    chk("mid-eval b.done before reset", 32'(b_done), 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset a.done", 32'(a_done), 32'd0);
    chk("async reset b.done", 32'(b_done), 32'd0);
    model_reset();
    check_model("in-rst");
    @(posedge clk);
    #1;
    check_model("rst-edge");
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Unconditional PC write with no evaluation pending.
    drive(0,0,0,0,0, 0,4'd0, 1,0);
    #1;
    chk("pc_write alone a.pcwe", 32'(a_pcwe), 32'd1);
    chk("pc_write alone b.done", 32'(b_done), 32'd0);
    @(negedge clk);
    check_model("pcw");
    @(posedge clk);
    model_edge();
    #1;
    pc_write = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
